// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory controller.
// The optional watchdog is enabled with the DMEM_TIMEOUT_EN macro.
package dmem_pkg;

    localparam int DMEM_ADDR_W      = 7;
    localparam int DMEM_DATA_W      = 32;
    localparam int DMEM_TIMEOUT_CYC = 64;

    // Returned to the core when a read is abandoned by the watchdog.
    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_wdog.sv
// Watchdog for the WAIT state of dmem_ctrl.
// It is instantiated only when DMEM_TIMEOUT_EN is defined.
// expire_o is asserted during the WAIT cycle whose increment would reach TIMEOUT_CYC,
// so the FSM leaves WAIT at the end of that cycle.
module dmem_wdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    // Count WAIT cycles that end without an ack; saturate at the limit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Flag the cycle whose increment would reach the limit.
    always_comb begin
        expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the single-cycle core's SRAM-style port and a
// req/ack backing memory. Each core access becomes one transaction, and the core
// is stalled until that transaction completes.
// Optional watchdog: define DMEM_TIMEOUT_EN to abandon a transaction after
// TIMEOUT_CYC WAIT cycles with no ack.
//
// state | meaning
// IDLE  | no transaction; capture the access when core_cen=0
// WAIT  | request outstanding; hold mem_* until ack (or timeout)
// DONE  | one unstalled cycle so the core can retire the access
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
`ifdef DMEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = DMEM_TIMEOUT_CYC
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_cen,
    input  logic              core_wen,
    input  logic              core_oen,
    input  logic [ADDR_W-1:0] core_a,
    input  logic [DATA_W-1:0] core_d,
    output logic [DATA_W-1:0] core_q,
    output logic              core_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    dmem_state_e       state_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              expire;

`ifdef DMEM_TIMEOUT_EN
    logic wdog_clr;
    logic wdog_en;

    // The watchdog clears on entry to WAIT and counts WAIT cycles that have no ack.
    always_comb begin
        wdog_clr = (state_q == IDLE) && !core_cen;
        wdog_en  = (state_q == WAIT) && !mem_ack;
    end

    dmem_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (wdog_clr),
        .en_i     (wdog_en),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Transaction FSM. All memory-side outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!core_cen) begin
                        addr_q  <= core_a;
                        we_q    <= ~core_wen;
                        wdata_q <= core_d;
                        req_q   <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack in the same cycle as expiry takes priority.
                    if (mem_ack) begin
                        req_q   <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= mem_rdata;
                        end
                        state_q <= DONE;
                    end else if (expire) begin
                        req_q   <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= DATA_W'(DMEM_ERR_DATA);
                        end
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                // The core's still-low core_cen here belongs to the access just served.
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Stall the core in the same cycle that it issues the access, and release it only in DONE.
    always_comb begin
        case (state_q)
            IDLE:    core_stall = ~core_cen;
            WAIT:    core_stall = 1'b1;
            DONE:    core_stall = 1'b0;
            default: core_stall = 1'b0;
        endcase
    end

    // Output-enable gating of the read-data register.
    always_comb begin
        core_q = core_oen ? '0 : rdata_q;
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl. A backing-memory array answers the DUT's
// requests. A core-side reference memory predicts what each read must return.
module tb_dmem_ctrl;

`ifdef DMEM_TIMEOUT_EN
    localparam int TO = 8;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_cen;
    logic        core_wen;
    logic        core_oen;
    logic [6:0]  core_a;
    logic [31:0] core_d;
    logic [31:0] core_q;
    logic        core_stall;
    logic        mem_req;
    logic        mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] bmem    [128];
    logic [31:0] ref_mem [128];
    logic [31:0] exp_qreg = 32'h0;
    logic        exp_err  = 1'b0;

    int req_pulses = 0;
    bit req_prev   = 1'b0;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .ADDR_W (7)
`ifdef DMEM_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TO)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_cen   (core_cen),
        .core_wen   (core_wen),
        .core_oen   (core_oen),
        .core_a     (core_a),
        .core_d     (core_d),
        .core_q     (core_q),
        .core_stall (core_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    always @(negedge clk) begin
        if (mem_req === 1'b1 && !req_prev) req_pulses++;
        req_prev = (mem_req === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "tb_dmem_ctrl watchdog");
    end

    // Perform one core access. Entered just after a rising edge with the DUT in IDLE.
    // nwait is the WAIT cycle in which the memory acks (0 means never).
    task automatic access(input bit we, input logic [6:0] a, input logic [31:0] d,
                          input int nwait, input bit oen, input bit gap);
        int stalls;
        int waits;
        int i;
        bit timed_out;
        bit ack_now;
        logic [31:0] want_q;
        timed_out = 1'b0;
        waits     = nwait;
`ifdef DMEM_TIMEOUT_EN
        if (nwait == 0 || nwait > TO) begin
            timed_out = 1'b1;
            waits     = TO;
        end
`endif
        core_cen = 1'b0; core_wen = !we; core_a = a; core_d = d; core_oen = oen;
        stalls = 0;
        @(negedge clk);
        if (core_stall === 1'b1) stalls++;
        n_tests++;
        if (core_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL capture_stall a=%h: got %b want 1", a, core_stall);
        end
        @(posedge clk); #1;
        i = 0;
        while (1) begin
            i++;
            ack_now   = !timed_out && (i == nwait);
            mem_ack   = ack_now;
            mem_rdata = ack_now ? bmem[mem_addr] : $urandom;
            @(negedge clk);
            if (core_stall === 1'b1) stalls++;
            n_tests++;
            if (core_stall !== 1'b1 || mem_req !== 1'b1 || mem_we !== we ||
                mem_addr !== a || mem_wdata !== d) begin
                n_fail++;
                $display("FAIL wait_cycle%0d: stall=%b req=%b we=%b addr=%h wdata=%h, want 1 1 %b %h %h",
                         i, core_stall, mem_req, mem_we, mem_addr, mem_wdata, we, a, d);
            end
            if (ack_now && mem_we === 1'b1) bmem[mem_addr] = mem_wdata;
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (ack_now || (timed_out && i == waits)) break;
            if (i >= 200) begin
                n_tests++; n_fail++;
                $display("FAIL wait_bound: no completion after %0d cycles", i);
                break;
            end
        end
        if (we) ref_mem[a] = d;
        else    exp_qreg   = timed_out ? 32'hDEAD_BEEF : ref_mem[a];
        if (timed_out) exp_err = 1'b1;
        want_q = oen ? 32'h0 : exp_qreg;
        @(negedge clk);
        n_tests++;
        if (core_stall !== 1'b0 || mem_req !== 1'b0 || core_q !== want_q ||
            err !== exp_err || stalls != 1 + waits) begin
            n_fail++;
            $display("FAIL done a=%h: stall=%b req=%b q=%h err=%b stalls=%0d, want 0 0 %h %b %0d",
                     a, core_stall, mem_req, core_q, err, stalls, want_q, exp_err, 1 + waits);
        end
        @(posedge clk); #1;
        core_cen = 1'b1; core_wen = 1'b1;
        if (gap) begin
            @(negedge clk);
            n_tests++;
            if (core_stall !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after: stall=%b req=%b want 0 0", core_stall, mem_req);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        core_cen = 1'b1; core_wen = 1'b1; core_oen = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        exp_qreg = 32'h0;
        exp_err  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 7'h0 || mem_wdata !== 32'h0 ||
            core_q !== 32'h0 || err !== 1'b0 || core_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h q=%h err=%b stall=%b, want all 0",
                     mem_req, mem_we, mem_addr, mem_wdata, core_q, err, core_stall);
        end
        core_cen = 1'b0;
        #1;
        n_tests++;
        if (core_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_stall_comb: got %b want 1", core_stall);
        end
        core_cen = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_fast();
        bmem[5] = 32'h1234_5678; ref_mem[5] = 32'h1234_5678;
        access(1'b0, 7'h05, $urandom, 1, 1'b0, 1'b1);
    endtask

    task automatic test_write_slow();
        access(1'b1, 7'h7F, 32'hCAFE_F00D, 4, 1'b0, 1'b1);
        access(1'b0, 7'h7F, $urandom, 2, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int p0;
        p0 = req_pulses;
        access(1'b0, 7'h01, $urandom, 1 + int'($urandom % 3), 1'b0, 1'b0);
        access(1'b0, 7'h02, $urandom, 1 + int'($urandom % 3), 1'b0, 1'b1);
        n_tests++;
        if (req_pulses - p0 != 2) begin
            n_fail++;
            $display("FAIL b2b_req_pulses: got %0d want 2", req_pulses - p0);
        end
    endtask

    task automatic test_reset_mid();
        core_cen = 1'b0; core_wen = 1'b1; core_a = 7'h03; core_d = $urandom; core_oen = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_qreg = 32'h0;
        exp_err  = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b0 || core_stall !== 1'b1 || core_q !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: req=%b stall=%b q=%h, want 0 1 0", mem_req, core_stall, core_q);
        end
        core_cen = 1'b1;
        #1;
        n_tests++;
        if (core_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle_stall: got %b want 0", core_stall);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_req: got %b want 0", mem_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_spurious_oen();
        core_cen = 1'b1; core_oen = 1'b0;
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b0 || core_stall !== 1'b0 || core_q !== exp_qreg) begin
            n_fail++;
            $display("FAIL spurious_ack: req=%b stall=%b q=%h, want 0 0 %h", mem_req, core_stall, core_q, exp_qreg);
        end
        @(posedge clk); #1;
        bmem[9] = 32'hA5A5_0F0F; ref_mem[9] = 32'hA5A5_0F0F;
        access(1'b0, 7'h09, $urandom, 1, 1'b1, 1'b1);
        core_oen = 1'b0;
        #1;
        n_tests++;
        if (core_q !== 32'hA5A5_0F0F) begin
            n_fail++;
            $display("FAIL oen_gate: got %h want a5a50f0f", core_q);
        end
        core_oen = 1'b1;
        #1;
        n_tests++;
        if (core_q !== 32'h0) begin
            n_fail++;
            $display("FAIL oen_gate_off: got %h want 0", core_q);
        end
        core_oen = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0] a;
        for (int k = 0; k < 40; k++) begin
            a = ($urandom % 5 == 0) ? 7'h7F : 7'($urandom % 8);
            access(bit'($urandom % 2), a, $urandom, 1 + int'($urandom % 6),
                   ($urandom % 4) == 0, bit'($urandom % 2));
        end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        bmem[4] = 32'h0BAD_F00D; ref_mem[4] = 32'h0BAD_F00D;
        access(1'b0, 7'h04, $urandom, TO, 1'b0, 1'b1);
        access(1'b0, 7'h06, $urandom, 0, 1'b0, 1'b1);
        access(1'b0, 7'h04, $urandom, 2, 1'b0, 1'b1);
        apply_reset();
        @(negedge clk);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_reset: got %b want 0", err);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            bmem[i] = v;
            ref_mem[i] = v;
        end
        rst_n = 1'b0; core_cen = 1'b1; core_wen = 1'b1; core_oen = 1'b0;
        core_a = '0; core_d = '0; mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_read_fast();
        test_write_slow();
        test_back_to_back();
        test_reset_mid();
        test_spurious_oen();
        test_random();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
